// File: rtl/band_scale.sv
// Per-band gain stage: five signed bands times five unsigned 12-bit gains through one
// shared multiplier, all results published together. Optional clamp: SCALE_SAT_EN.
module band_scale (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] LP_in,
  input  logic [15:0] B1_in,
  input  logic [15:0] B2_in,
  input  logic [15:0] B3_in,
  input  logic [15:0] HP_in,
  input  logic [11:0] LP_pot,
  input  logic [11:0] B1_pot,
  input  logic [11:0] B2_pot,
  input  logic [11:0] B3_pot,
  input  logic [11:0] HP_pot,
  output logic [15:0] LP_scl,
  output logic [15:0] B1_scl,
  output logic [15:0] B2_scl,
  output logic [15:0] B3_scl,
  output logic [15:0] HP_scl,
  output logic        valid,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [4:0][15:0] band_q, band_d;
  logic [4:0][11:0] pot_q, pot_d;
  logic [3:0][15:0] shadow_q, shadow_d;
  logic [4:0][15:0] scl_q, scl_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [28:0] band_ext;
  logic [28:0] gain_ext;
  logic [28:0] prod;
  logic [17:0] shifted;
  logic [15:0] result;
  logic        prod_unused;

  // Sign-extend the band and zero-extend the gain to the full product width; the low
  // 29 bits of the unsigned product are then the exact two's-complement result.
  always_comb begin
    band_ext = {{13{band_q[idx_q][15]}}, band_q[idx_q]};
    gain_ext = {17'd0, pot_q[idx_q]};
    prod     = band_ext * gain_ext;
    shifted  = prod[28:11];
  end

`ifdef SCALE_SAT_EN
  always_comb begin
    if (shifted[17:15] != {3{shifted[17]}}) begin
      result = shifted[17] ? 16'h8000 : 16'h7FFF;
    end else begin
      result = shifted[15:0];
    end
  end
  assign prod_unused = ^prod[10:0];
`else
  assign result      = shifted[15:0];
  assign prod_unused = ^{prod[10:0], shifted[17:16]};
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    band_d   = band_q;
    pot_d    = pot_q;
    shadow_d = shadow_q;
    scl_d    = scl_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          band_d  = {HP_in, B3_in, B2_in, B1_in, LP_in};
          pot_d   = {HP_pot, B3_pot, B2_pot, B1_pot, LP_pot};
          idx_d   = 3'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (idx_q == 3'd4) begin
          // HP bypasses the shadows so all five outputs land on the same edge.
          scl_d   = {result, shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
          valid_d = 1'b1;
          idx_d   = 3'd0;
          state_d = S_IDLE;
        end else begin
          shadow_d[idx_q[1:0]] = result;
          idx_d                = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL);
  end

  always_ff @(posedge clk) begin
    // NOTE: holding and shadow registers are reset too, so a sample aborted by reset
    // leaves no stale data behind and every output reads back as zero.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      band_q   <= '0;
      pot_q    <= '0;
      shadow_q <= '0;
      scl_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      band_q   <= band_d;
      pot_q    <= pot_d;
      shadow_q <= shadow_d;
      scl_q    <= scl_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign LP_scl = scl_q[0];
  assign B1_scl = scl_q[1];
  assign B2_scl = scl_q[2];
  assign B3_scl = scl_q[3];
  assign HP_scl = scl_q[4];
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule
